// File: rtl/home_sim_pkg.sv
// Shared constants and the room draw scheduler state type.
package home_sim_pkg;

   localparam int NUM_ROOMS = 10;

   localparam logic FUNC_LIGHT = 1'b1;
   localparam logic FUNC_DOOR  = 1'b0;
   localparam logic ST_ON      = 1'b1;
   localparam logic ST_OFF     = 1'b0;

   typedef enum logic [2:0] {
      S_CLEAR_ISSUE,
      S_CLEAR_WAIT,
      S_IDLE,
      S_ISSUE,
      S_DRAW_WAIT
   } sched_state_t;

endpackage

// File: rtl/rr_room_picker.sv
// Round-robin room picker: first set bit of pending strictly after rr_ptr,
// wrapping modulo NUM_ROOMS. Rotate, priority encode, un-rotate.
module rr_room_picker #(
   parameter int NUM_ROOMS = 10,
   parameter int ROOM_W    = 4
) (
   input  logic [NUM_ROOMS-1:0] pending,
   input  logic [ROOM_W-1:0]    rr_ptr,
   output logic [ROOM_W-1:0]    grant,
   output logic                 valid
);

   localparam logic [ROOM_W-1:0] LAST_ROOM = ROOM_W'(NUM_ROOMS - 1);
   localparam logic [ROOM_W:0]   ROOMS_EXT = (ROOM_W + 1)'(NUM_ROOMS);

   logic [ROOM_W-1:0]      start;
   logic [2*NUM_ROOMS-1:0] doubled;
   logic [NUM_ROOMS-1:0]   rotated;
   logic [ROOM_W-1:0]      offset;
   logic [ROOM_W:0]        sum;

   // Rotate so the room after rr_ptr sits at bit 0, pick the lowest set bit,
   // then map the offset back to an absolute room index.
   always_comb begin
      start   = (rr_ptr >= LAST_ROOM) ? '0 : rr_ptr + ROOM_W'(1);
      doubled = {pending, pending} >> start;
      rotated = doubled[NUM_ROOMS-1:0];
      offset  = '0;
      valid   = 1'b0;
      for (int i = NUM_ROOMS - 1; i >= 0; i--) begin
         if (rotated[i]) begin
            offset = ROOM_W'(i);
            valid  = 1'b1;
         end
      end
      sum = {1'b0, offset} + {1'b0, start};
      if (sum >= ROOMS_EXT) begin
         sum = sum - ROOMS_EXT;
      end
      grant = sum[ROOM_W-1:0];
   end

endmodule

// File: rtl/room_draw_scheduler.sv
// Room draw scheduler: queues per-room redraw requests and feeds them one at
// a time, round-robin, into the shared VGA draw engine; full-screen clears
// take priority over queued room draws but never abort one in flight.
//
// state         | meaning
// --------------+------------------------------------------------------------
// S_CLEAR_ISSUE | clear_start asserted this cycle, clear request consumed
// S_CLEAR_WAIT  | waiting for the engine to finish the clear (or timeout)
// S_IDLE        | nothing queued, waiting for a request or a clear
// S_ISSUE       | draw_start asserted this cycle; room and snapshots latched
// S_DRAW_WAIT   | waiting for the engine to finish the room draw (or timeout)
module room_draw_scheduler #(
   parameter int NUM_ROOMS = 10,
   parameter int ROOM_W    = 4,
   parameter int MAX_WAIT  = 4096
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic [NUM_ROOMS-1:0] req,
   input  logic [NUM_ROOMS-1:0] room_funct,
   input  logic [NUM_ROOMS-1:0] room_onoff,
   input  logic                 clear_req,
   input  logic                 countDone,
   output logic                 draw_start,
   output logic [ROOM_W-1:0]    draw_room,
   output logic                 draw_funct,
   output logic                 draw_onoff,
   output logic                 clear_start,
   output logic                 busy,
   output logic [NUM_ROOMS-1:0] pending,
   output logic                 Donesig,
   output logic                 timeout_err
);

   import home_sim_pkg::*;

   localparam int                WAIT_W    = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

   sched_state_t         state;
   logic                 clear_pend;
   logic [ROOM_W-1:0]    rr_ptr;
   logic [WAIT_W-1:0]    wait_cnt;

   logic                 wait_state;
   logic                 wait_expired;
   logic                 wait_done;
   logic [NUM_ROOMS-1:0] room_onehot;
   logic [NUM_ROOMS-1:0] pick_src;
   logic [ROOM_W-1:0]    grant;
   logic                 grant_valid;
   logic [NUM_ROOMS-1:0] grant_onehot;
   logic                 do_issue;

   assign wait_state   = (state == S_CLEAR_WAIT) || (state == S_DRAW_WAIT);
   assign wait_expired = wait_state && !countDone && (wait_cnt == WAIT_LAST);
   assign wait_done    = wait_state && (countDone || wait_expired);
   assign room_onehot  = NUM_ROOMS'(1) << draw_room;
   assign grant_onehot = NUM_ROOMS'(1) << grant;

   // The queue the picker sees on a completion edge: a finished clear queues
   // every room, an expired draw puts its own room back for a later retry.
   always_comb begin
      pick_src = pending;
      if (state == S_CLEAR_WAIT) begin
         pick_src = '1;
      end else if ((state == S_DRAW_WAIT) && wait_expired) begin
         pick_src = pending | room_onehot;
      end
   end

   rr_room_picker #(
      .NUM_ROOMS(NUM_ROOMS),
      .ROOM_W   (ROOM_W)
   ) u_picker (
      .pending(pick_src),
      .rr_ptr (rr_ptr),
      .grant  (grant),
      .valid  (grant_valid)
   );

   // Grant is taken on the edge entering S_ISSUE so that draw_room and the
   // snapshots are already valid in the cycle draw_start is high.
   always_comb begin
      do_issue = 1'b0;
      case (state)
         S_IDLE:       do_issue = !clear_pend && grant_valid;
         S_CLEAR_WAIT: do_issue = wait_done;
         S_DRAW_WAIT:  do_issue = wait_done && !clear_pend && grant_valid;
         default:      do_issue = 1'b0;
      endcase
   end

   // Start pulses decode the state register; clear_start is held off while
   // reset is asserted because reset parks the FSM in S_CLEAR_ISSUE.
   assign draw_start  = (state == S_ISSUE);
   assign clear_start = (state == S_CLEAR_ISSUE) && !reset;
   assign busy        = (state != S_IDLE);
   assign timeout_err = wait_expired;

   // Scheduler FSM with request queue, wait counter and issue snapshots.
   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= S_CLEAR_ISSUE;
         pending    <= '0;
         clear_pend <= 1'b0;
         rr_ptr     <= ROOM_W'(NUM_ROOMS - 1);
         wait_cnt   <= '0;
         draw_room  <= '0;
         draw_funct <= FUNC_DOOR;
         draw_onoff <= ST_OFF;
         Donesig    <= 1'b0;
      end else begin
         Donesig    <= 1'b0;
         pending    <= pending | req;
         clear_pend <= clear_pend | clear_req;
         case (state)
            S_CLEAR_ISSUE: begin
               clear_pend <= clear_req;
               wait_cnt   <= '0;
               state      <= S_CLEAR_WAIT;
            end
            S_CLEAR_WAIT: begin
               if (!wait_done) begin
                  wait_cnt <= wait_cnt + WAIT_W'(1);
               end
            end
            S_IDLE: begin
               if (clear_pend) begin
                  state <= S_CLEAR_ISSUE;
               end
            end
            S_ISSUE: begin
               wait_cnt <= '0;
               state    <= S_DRAW_WAIT;
            end
            S_DRAW_WAIT: begin
               if (wait_done) begin
                  if (clear_pend) begin
                     pending <= pick_src | req;
                     state   <= S_CLEAR_ISSUE;
                  end else if (!grant_valid) begin
                     Donesig <= 1'b1;
                     state   <= S_IDLE;
                  end
               end else begin
                  wait_cnt <= wait_cnt + WAIT_W'(1);
               end
            end
            default: state <= S_CLEAR_ISSUE;
         endcase
         if (do_issue) begin
            state      <= S_ISSUE;
            draw_room  <= grant;
            draw_funct <= room_funct[grant];
            draw_onoff <= room_onoff[grant];
            rr_ptr     <= grant;
            pending    <= (pick_src & ~grant_onehot) | req;
         end
      end
   end

endmodule
